// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
// Time-multiplexed seven-segment display driver. Captures DIGITS packed BCD
// codes plus per-digit decimal points. It scans them one digit at a time onto a
// shared segment bus with one-hot anode enables. New data is committed only on
// a scan wrap, so a frame never mixes old and new digits.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   bcd_in    in   4*DIGITS packed BCD codes, digit i at [4i+3:4i]
//   dp_in     in   DIGITS decimal-point requests
//   load      in   one-cycle capture strobe for bcd_in/dp_in
//   blank_lz  in   leading-zero blanking enable (live level)
//   enable    in   0 forces all anodes inactive, scanning continues
//   segment   out  {g,f,e,d,c,b,a}, registered
//   dp        out  decimal point of the active digit, registered
//   anode     out  one-hot digit enable, registered
//   frame     out  one-cycle pulse aligned with digit 0 of each new frame
//   pending   out  captured data is waiting for the next wrap
// -----------------------------------------------------------------------------
module sevenseg_scan_driver #(
   parameter int DIGITS         = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  load,
   input  logic                  blank_lz,
   input  logic                  enable,
   output logic [6:0]            segment,
   output logic                  dp,
   output logic [DIGITS-1:0]     anode,
   output logic                  frame,
   output logic                  pending
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
   // XOR masks turning active-high values into pin polarity.
   localparam logic [6:0]        SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic              DP_XOR  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [DIGITS-1:0] AN_XOR  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   // Active-high segment pattern for one BCD code; codes 10-15 show a dash.
   function automatic logic [6:0] decode_bcd(input logic [3:0] code);
      logic [6:0] pat;
      case (code)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         default: pat = 7'h40;
      endcase
      return pat;
   endfunction

   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   pend_bcd_q, pend_bcd_d, disp_bcd_q, disp_bcd_d;
   logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
   logic                  pending_q, pending_d;
   logic                  wrap_dly_q, frame_q;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic                  tick_s, wrap_s;
   logic [3:0]            cur_code_s;
   logic                  cur_dp_s, blank_s, upper_zero_s;
   logic [DIGITS-1:0]     onehot_s;

   // Prescaler and digit index next-state.
   always_comb begin
      tick_s = (presc_q == PRESC_LAST);
      wrap_s = tick_s && (idx_q == IDX_LAST);
      if (tick_s) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + PW'(1);
      end
      if (wrap_s) begin
         idx_d = '0;
      end else if (tick_s) begin
         idx_d = idx_q + IW'(1);
      end else begin
         idx_d = idx_q;
      end
   end

   // Capture/commit: a load on the wrap cycle bypasses the pending register.
   always_comb begin
      pend_bcd_d = pend_bcd_q;
      pend_dp_d  = pend_dp_q;
      disp_bcd_d = disp_bcd_q;
      disp_dp_d  = disp_dp_q;
      pending_d  = pending_q;
      if (load && wrap_s) begin
         disp_bcd_d = bcd_in;
         disp_dp_d  = dp_in;
         pending_d  = 1'b0;
      end else if (wrap_s && pending_q) begin
         disp_bcd_d = pend_bcd_q;
         disp_dp_d  = pend_dp_q;
         pending_d  = 1'b0;
      end else if (load) begin
         pend_bcd_d = bcd_in;
         pend_dp_d  = dp_in;
         pending_d  = 1'b1;
      end else begin
         pending_d  = pending_q;
      end
   end

   // Select the active digit and work out leading-zero blanking from the top down.
   always_comb begin
      cur_code_s   = 4'h0;
      cur_dp_s     = 1'b0;
      blank_s      = 1'b0;
      upper_zero_s = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (disp_bcd_q[4*i +: 4] != 4'h0) begin
            upper_zero_s = 1'b0;
         end else begin
            upper_zero_s = upper_zero_s;
         end
         if (idx_q == IW'(i)) begin
            cur_code_s = disp_bcd_q[4*i +: 4];
            cur_dp_s   = disp_dp_q[i];
            blank_s    = blank_lz && upper_zero_s && (i != 0);
         end else begin
            blank_s    = blank_s;
         end
      end
   end

   // Output next-state, polarity applied last.
   always_comb begin
      onehot_s = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
      if (!enable) begin
         seg_d = SEG_XOR;
         dp_d  = DP_XOR;
         an_d  = AN_XOR;
      end else if (blank_s) begin
         seg_d = SEG_XOR;
         dp_d  = DP_XOR;
         an_d  = onehot_s ^ AN_XOR;
      end else begin
         seg_d = decode_bcd(cur_code_s) ^ SEG_XOR;
         dp_d  = cur_dp_s ^ DP_XOR;
         an_d  = onehot_s ^ AN_XOR;
      end
   end

   // State and registered outputs. frame is delayed twice so it lines up with
   // the first registered anode of digit 0 in the new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q    <= '0;
         idx_q      <= '0;
         pend_bcd_q <= '0;
         pend_dp_q  <= '0;
         disp_bcd_q <= '0;
         disp_dp_q  <= '0;
         pending_q  <= 1'b0;
         wrap_dly_q <= 1'b0;
         frame_q    <= 1'b0;
         seg_q      <= SEG_XOR;
         dp_q       <= DP_XOR;
         an_q       <= AN_XOR;
      end else begin
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         pend_bcd_q <= pend_bcd_d;
         pend_dp_q  <= pend_dp_d;
         disp_bcd_q <= disp_bcd_d;
         disp_dp_q  <= disp_dp_d;
         pending_q  <= pending_d;
         wrap_dly_q <= wrap_s;
         frame_q    <= wrap_dly_q;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
      end
   end

   assign segment = seg_q;
   assign dp      = dp_q;
   assign anode   = an_q;
   assign frame   = frame_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_driver
// Directed bench for sevenseg_scan_driver with DIGITS=4, SCAN_DIV=4. A second
// instance with both polarities inverted shares all inputs. cyc counts rising
// edges since the last reset release. After edge k the registered outputs show
// digit ((k-1)/4)%4, and frame is high when k>=17 and (k-1)%16==0.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;
   logic        load, blank_lz, enable;
   logic [6:0]  segment, segment_inv;
   logic        dp, dp_inv, frame, frame_inv, pending, pending_inv;
   logic [3:0]  anode, anode_inv;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   localparam logic [27:0] S_ZERO = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
   localparam logic [27:0] S_1234 = {7'h06, 7'h5B, 7'h4F, 7'h66};
   localparam logic [27:0] S_9876 = {7'h6F, 7'h7F, 7'h07, 7'h7D};
   localparam logic [27:0] S_BLNK = {7'h00, 7'h00, 7'h40, 7'h6D};
   localparam logic [27:0] S_ZBLK = {7'h00, 7'h00, 7'h00, 7'h3F};
   localparam logic [27:0] S_0008 = {7'h3F, 7'h3F, 7'h3F, 7'h7F};

   always #5 clk = ~clk;

   sevenseg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut (
      .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
      .blank_lz(blank_lz), .enable(enable), .segment(segment), .dp(dp),
      .anode(anode), .frame(frame), .pending(pending)
   );

   sevenseg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_inv (
      .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
      .blank_lz(blank_lz), .enable(enable), .segment(segment_inv), .dp(dp_inv),
      .anode(anode_inv), .frame(frame_inv), .pending(pending_inv)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // One clock, then check the enabled main instance against a hand-made frame.
   task automatic tick_chk(input logic [27:0] segs, input logic [3:0] dps);
      int d;
      step();
      d = ((cyc - 1) / 4) % 4;
      check("anode", {28'd0, anode}, 32'd1 << d);
      check("segment", {25'd0, segment}, {25'd0, segs[7*d +: 7]});
      check("dp", {31'd0, dp}, {31'd0, dps[d]});
      check("frame", {31'd0, frame}, ((cyc >= 17) && ((cyc - 1) % 16 == 0)) ? 32'd1 : 32'd0);
   endtask

   task automatic run_check(input int upto, input logic [27:0] segs, input logic [3:0] dps);
      while (cyc < upto) tick_chk(segs, dps);
   endtask

   initial begin
      rst_n = 1'b0; bcd_in = 16'h0000; dp_in = 4'b0000;
      load = 1'b0; blank_lz = 1'b0; enable = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      // Reset state
      check("rst_anode", {28'd0, anode}, 32'h0);
      check("rst_segment", {25'd0, segment}, 32'h0);
      check("rst_dp", {31'd0, dp}, 32'h0);
      check("rst_frame", {31'd0, frame}, 32'h0);
      check("rst_pending", {31'd0, pending}, 32'h0);
      check("rst_anode_inv", {28'd0, anode_inv}, 32'hF);
      check("rst_segment_inv", {25'd0, segment_inv}, 32'h7F);
      check("rst_dp_inv", {31'd0, dp_inv}, 32'h1);
      rst_n = 1'b1;
      cyc = 0;
      #1;
      check("rel_anode_first", {28'd0, anode}, 32'h0);

      // Reset scan: two frames of zeros
      run_check(32, S_ZERO, 4'b0000);

      // Frame-aligned commit of 1234, loaded while digit 1 is shown
      run_check(37, S_ZERO, 4'b0000);
      bcd_in = 16'h1234; load = 1'b1;
      tick_chk(S_ZERO, 4'b0000);
      load = 1'b0;
      check("pend_set", {31'd0, pending}, 32'h1);
      while (cyc < 47) begin
         tick_chk(S_ZERO, 4'b0000);
         check("pend_hold", {31'd0, pending}, 32'h1);
      end
      tick_chk(S_ZERO, 4'b0000);
      check("pend_commit", {31'd0, pending}, 32'h0);
      run_check(64, S_1234, 4'b0000);

      // Load collision: 1111 mid-frame, 9876 on the wrap cycle
      run_check(70, S_1234, 4'b0000);
      bcd_in = 16'h1111; load = 1'b1;
      tick_chk(S_1234, 4'b0000);
      load = 1'b0;
      check("coll_pend_set", {31'd0, pending}, 32'h1);
      run_check(79, S_1234, 4'b0000);
      bcd_in = 16'h9876; load = 1'b1;
      tick_chk(S_1234, 4'b0000);
      load = 1'b0;
      check("coll_pend_clear", {31'd0, pending}, 32'h0);
      run_check(96, S_9876, 4'b0000);

      // Blanking, dash and decimal point
      run_check(100, S_9876, 4'b0000);
      bcd_in = 16'h00F5; dp_in = 4'b0010; blank_lz = 1'b1; load = 1'b1;
      tick_chk(S_9876, 4'b0000);
      load = 1'b0;
      run_check(112, S_9876, 4'b0000);
      run_check(116, S_BLNK, 4'b0010);
      bcd_in = 16'h0000; dp_in = 4'b0000; load = 1'b1;
      tick_chk(S_BLNK, 4'b0010);
      load = 1'b0;
      run_check(128, S_BLNK, 4'b0010);
      run_check(130, S_ZBLK, 4'b0000);

      // Polarity and enable: show 0008, blanking off from the wrap
      bcd_in = 16'h0008; load = 1'b1;
      tick_chk(S_ZBLK, 4'b0000);
      load = 1'b0;
      run_check(144, S_ZBLK, 4'b0000);
      blank_lz = 1'b0;
      tick_chk(S_0008, 4'b0000);
      check("inv_seg_8", {25'd0, segment_inv}, 32'h00);
      check("inv_anode_d0", {28'd0, anode_inv}, 32'hE);
      check("inv_dp_off", {31'd0, dp_inv}, 32'h1);
      enable = 1'b0;
      while (cyc < 152) begin
         step();
         check("dis_anode", {28'd0, anode}, 32'h0);
         check("dis_segment", {25'd0, segment}, 32'h0);
         check("dis_anode_inv", {28'd0, anode_inv}, 32'hF);
         check("dis_segment_inv", {25'd0, segment_inv}, 32'h7F);
         check("dis_dp_inv", {31'd0, dp_inv}, 32'h1);
      end
      enable = 1'b1;
      tick_chk(S_0008, 4'b0000);
      check("reen_anode_inv", {28'd0, anode_inv}, 32'hB);
      check("reen_segment_inv", {25'd0, segment_inv}, 32'h40);
      run_check(160, S_0008, 4'b0000);

      // Async reset with pending data
      bcd_in = 16'h5555; load = 1'b1;
      tick_chk(S_0008, 4'b0000);
      load = 1'b0;
      check("ar_pend_set", {31'd0, pending}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_anode", {28'd0, anode}, 32'h0);
      check("ar_segment", {25'd0, segment}, 32'h0);
      check("ar_pending", {31'd0, pending}, 32'h0);
      check("ar_anode_inv", {28'd0, anode_inv}, 32'hF);
      check("ar_segment_inv", {25'd0, segment_inv}, 32'h7F);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      cyc = 0;
      #1;
      check("ar_rel_anode", {28'd0, anode}, 32'h0);
      while (cyc < 16) begin
         tick_chk(S_ZERO, 4'b0000);
         check("ar_pend_clear", {31'd0, pending}, 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
